ucode_seq: RTL and testbench

UCODE_SEQ -- requirements
Module: ucode_seq

---
 rtl/ucode_seq.sv | 165 ++++++++++++++++
 tb/tb_ucode_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ucode_seq.sv
// Micro-code M-cycle sequencer: walks an opcode's step list, handles HALT and interrupt dispatch.
// Latency: outputs are combinational decodes of registered state, and the state advances one step per clock.
// Backpressure: stall holds idx, irq_step and state, and suppresses fetch and irq_ack.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   step_vec                      packed step codes, step k at [k*STEP_W +: STEP_W]
//   last_idx                      final step index (clamped to MAX_STEPS-1)
//   cond_en/cond_idx/cond_met     optional early exit when the condition is false at cond_idx
//   stall                         memory not ready; freeze the sequencer
//   ime, irq_pending              interrupt enable and request
//   step, idx                     active step code and its index
//   fetch                         opcode fetch this cycle
//   irq_step, in_irq, irq_ack     interrupt dispatch progress
//   halted                        core is in HALT
module ucode_seq #(
  parameter int                MAX_STEPS = 6,
  parameter int                STEP_W    = 4,
  parameter int                IRQ_LEN   = 5,
  parameter logic [STEP_W-1:0] HALT_CODE = '1,
  localparam int               IDX_W     = $clog2(MAX_STEPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_STEPS*STEP_W-1:0]   step_vec,
  input  logic [IDX_W-1:0]              last_idx,
  input  logic                          cond_en,
  input  logic [IDX_W-1:0]              cond_idx,
  input  logic                          cond_met,
  input  logic                          stall,
  input  logic                          ime,
  input  logic                          irq_pending,
  output logic [STEP_W-1:0]             step,
  output logic [IDX_W-1:0]              idx,
  output logic                          fetch,
  output logic [2:0]                    irq_step,
  output logic                          in_irq,
  output logic                          irq_ack,
  output logic                          halted
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_IRQ  = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   MAX_V    = (IDX_W+1)'(MAX_STEPS);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_STEPS - 1);
  localparam logic [2:0]       IRQ_LAST = 3'(IRQ_LEN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       irq_step_q, irq_step_d;

  state_t           cur_state;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] eff_last;
  logic             cond_ok;
  logic             is_last;
  logic [STEP_W-1:0] run_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      idx_q      <= '0;
      irq_step_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      irq_step_q <= irq_step_d;
    end
  end

  always_comb begin
    // While reset is asserted the outputs already look like RUN at idx 0,
    // so nothing from an aborted HALT/IRQ leaks out during the reset cycle.
    cur_state = rst ? ST_RUN : state_q;
    cur_idx   = rst ? '0 : idx_q;

    eff_last = ({1'b0, last_idx} >= MAX_V) ? IDX_MAX : last_idx;
    // A condition index beyond the final step can never be reached.
    cond_ok  = cond_en && (cond_idx <= eff_last);

    run_code = '0;
    for (int k = 0; k < MAX_STEPS; k++) begin
      if (cur_idx == IDX_W'(k)) run_code = step_vec[k*STEP_W +: STEP_W];
    end

    is_last = (cur_idx >= eff_last) || (cond_ok && (cur_idx == cond_idx) && !cond_met);

    state_d    = state_q;
    idx_d      = idx_q;
    irq_step_d = irq_step_q;
    step       = '0;
    idx        = cur_idx;
    fetch      = 1'b0;
    in_irq     = 1'b0;
    irq_ack    = 1'b0;
    halted     = 1'b0;

    case (cur_state)
      ST_RUN: begin
        step = run_code;
        if (!stall) begin
          // HALT wins over both the normal fetch and interrupt entry.
          if (run_code == HALT_CODE) begin
            state_d = ST_HALT;
            idx_d   = '0;
          end else if (!is_last) begin
            idx_d = cur_idx + IDX_W'(1);
          end else if (ime && irq_pending) begin
            state_d    = ST_IRQ;
            idx_d      = '0;
            irq_step_d = '0;
          end else begin
            fetch = 1'b1;
            idx_d = '0;
          end
        end
      end

      ST_HALT: begin
        halted = 1'b1;
        idx    = '0;
        if (!stall && irq_pending) begin
          idx_d = '0;
          if (ime) begin
            state_d    = ST_IRQ;
            irq_step_d = '0;
          end else begin
            fetch   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end

      ST_IRQ: begin
        in_irq = 1'b1;
        idx    = '0;
        // irq_pending is deliberately not looked at here.
        if (!stall) begin
          if (irq_step_q == IRQ_LAST) begin
            irq_ack    = 1'b1;
            fetch      = 1'b1;
            state_d    = ST_RUN;
            idx_d      = '0;
            irq_step_d = '0;
          end else begin
            irq_step_d = irq_step_q + 3'd1;
          end
        end
      end

      default: begin
        state_d    = ST_RUN;
        idx_d      = '0;
        irq_step_d = '0;
      end
    endcase
  end

  assign irq_step = in_irq ? irq_step_q : 3'd0;

endmodule

// File: tb/tb_ucode_seq.sv
// Self-checking bench for ucode_seq with a cycle-level behavioural model.
// Latency: each cycle's outputs are compared against the model between clock edges.
// Backpressure: stall is exercised both in directed scenarios and randomly.
module tb_ucode_seq;

  localparam int MS = 6;
  localparam int IL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] step_vec;
  logic [2:0]  last_idx;
  logic        cond_en;
  logic [2:0]  cond_idx;
  logic        cond_met;
  logic        stall;
  logic        ime;
  logic        irq_pending;
  logic [3:0]  step;
  logic [2:0]  idx;
  logic        fetch;
  logic [2:0]  irq_step;
  logic        in_irq;
  logic        irq_ack;
  logic        halted;

  ucode_seq dut (
    .clk         (clk),
    .rst         (rst),
    .step_vec    (step_vec),
    .last_idx    (last_idx),
    .cond_en     (cond_en),
    .cond_idx    (cond_idx),
    .cond_met    (cond_met),
    .stall       (stall),
    .ime         (ime),
    .irq_pending (irq_pending),
    .step        (step),
    .idx         (idx),
    .fetch       (fetch),
    .irq_step    (irq_step),
    .in_irq      (in_irq),
    .irq_ack     (irq_ack),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: mode 0 = running the opcode, 1 = halted, 2 = interrupt dispatch.
  int m_mode = 0;
  int m_pos  = 0;
  int m_ic   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called just after a rising edge with inputs already applied: checks the
  // outputs against the model, then steps the model across the next edge.
  task automatic do_cycle();
    int mode, pos, ic, lastc, code;
    int n_mode, n_pos, n_ic;
    int e_step, e_idx, e_fetch, e_halt, e_irq, e_ack, e_is;
    bit last;
    #2;
    mode  = rst ? 0 : m_mode;
    pos   = rst ? 0 : m_pos;
    ic    = m_ic;
    lastc = (int'(last_idx) >= MS) ? MS - 1 : int'(last_idx);
    n_mode = mode; n_pos = pos; n_ic = ic;
    e_step = 0; e_idx = 0; e_fetch = 0; e_halt = 0; e_irq = 0; e_ack = 0; e_is = 0;
    if (mode == 0) begin
      code   = int'((step_vec >> (4 * pos)) & 24'hF);
      e_step = code;
      e_idx  = pos;
      last   = (pos >= lastc) ||
               (cond_en && int'(cond_idx) <= lastc && pos == int'(cond_idx) && !cond_met);
      if (!stall) begin
        if (code == 15) begin
          n_mode = 1; n_pos = 0;
        end else if (!last) begin
          n_pos = pos + 1;
        end else if (ime && irq_pending) begin
          n_mode = 2; n_pos = 0; n_ic = 0;
        end else begin
          e_fetch = 1; n_pos = 0;
        end
      end
    end else if (mode == 1) begin
      e_halt = 1;
      if (!stall && irq_pending) begin
        if (ime) begin
          n_mode = 2; n_ic = 0;
        end else begin
          e_fetch = 1; n_mode = 0; n_pos = 0;
        end
      end
    end else begin
      e_irq = 1;
      e_is  = ic;
      if (!stall) begin
        if (ic == IL - 1) begin
          e_ack = 1; e_fetch = 1; n_mode = 0; n_pos = 0; n_ic = 0;
        end else begin
          n_ic = ic + 1;
        end
      end
    end
    if (rst) begin
      n_mode = 0; n_pos = 0; n_ic = 0;
    end
    check("step",    32'(step),    32'(e_step));
    check("idx",     32'(idx),     32'(e_idx));
    check("fetch",   32'(fetch),   32'(e_fetch));
    check("halted",  32'(halted),  32'(e_halt));
    check("in_irq",  32'(in_irq),  32'(e_irq));
    check("irq_ack", 32'(irq_ack), 32'(e_ack));
    if (e_irq != 0) check("irq_step", 32'(irq_step), 32'(e_is));
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pos = n_pos; m_ic = n_ic;
  endtask

  task automatic run_to_last();
    for (int i = 0; i < 12 && !(m_mode == 0 && m_pos == int'(last_idx)); i++) do_cycle();
    check("reach_last", 32'(m_pos), 32'(last_idx));
  endtask

  initial begin
    rst = 1'b1; step_vec = 24'h654321; last_idx = 3'd3;
    cond_en = 1'b0; cond_idx = 3'd0; cond_met = 1'b0;
    stall = 1'b0; ime = 1'b0; irq_pending = 1'b0;
    repeat (2) do_cycle();
    rst = 1'b0;

    // Unconditional sequence 0,1,2,3,0.
    repeat (5) do_cycle();

    // Conditional exit, not taken then taken.
    last_idx = 3'd4; cond_en = 1'b1; cond_idx = 3'd1; cond_met = 1'b0;
    repeat (6) do_cycle();
    cond_met = 1'b1;
    repeat (7) do_cycle();
    cond_en = 1'b0;

    // Two-cycle stall at idx 2.
    for (int i = 0; i < 10 && m_pos != 2; i++) do_cycle();
    check("stall_pos", 32'(m_pos), 32'd2);
    stall = 1'b1;
    repeat (2) do_cycle();
    stall = 1'b0;
    repeat (4) do_cycle();

    // HALT code at idx 1; wake without ime.
    last_idx = 3'd3;
    for (int i = 0; i < 10 && m_pos != 0; i++) do_cycle();
    step_vec = 24'h6543F1;
    repeat (2) do_cycle();
    repeat (3) do_cycle();
    step_vec = 24'h654321;
    irq_pending = 1'b1;
    do_cycle();
    irq_pending = 1'b0;
    repeat (3) do_cycle();

    // Interrupt taken at the last step.
    ime = 1'b1;
    run_to_last();
    irq_pending = 1'b1;
    do_cycle();
    irq_pending = 1'b0;
    repeat (6) do_cycle();

    // Reset in the middle of dispatch.
    run_to_last();
    irq_pending = 1'b1;
    do_cycle();
    irq_pending = 1'b0;
    repeat (2) do_cycle();
    check("irq_mid", 32'(m_ic), 32'd2);
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    repeat (6) do_cycle();

    // Random traffic.
    repeat (3000) begin
      rst         = ($urandom_range(0, 99) < 2);
      stall       = ($urandom_range(0, 99) < 20);
      ime         = ($urandom_range(0, 1) == 1);
      irq_pending = ($urandom_range(0, 99) < 15);
      cond_en     = ($urandom_range(0, 1) == 1);
      cond_met    = ($urandom_range(0, 1) == 1);
      cond_idx    = 3'($urandom_range(0, 7));
      last_idx    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) step_vec = 24'($urandom);
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
